// File: rtl/score_tracker_pkg.sv
// rtl/score_tracker_pkg.sv - shared monster bus geometry and level limits
package score_tracker_pkg;

    localparam int MONSTERS   = 12;
    localparam int SLOT_W     = 19;
    localparam int SLOT_VALID = 0;
    localparam int MAX_LEVEL  = 7;

    // One bus slot, MSB first: y[18:11], x[10:3], dir[2:1], valid[0]
    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
        logic [1:0] dir;
        logic       valid;
    } slot_t;

endpackage

// File: rtl/score_tracker_bcd_counter4.sv
// rtl/score_tracker_bcd_counter4.sv - 4-digit BCD incrementer saturating at 9999
module bcd_counter4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_bcd
);

    logic [15:0] w_next;
    logic        w_carry;
    logic        w_sat;

    always_comb begin
        w_next  = o_bcd;
        w_carry = 1'b1;
        w_sat   = (o_bcd == 16'h9999);
        for (int d = 0; d < 4; d++) begin
            if (w_carry) begin
                if (o_bcd[d*4 +: 4] == 4'd9) begin
                    w_next[d*4 +: 4] = 4'd0;
                end else begin
                    w_next[d*4 +: 4] = o_bcd[d*4 +: 4] + 4'd1;
                    w_carry          = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            o_bcd <= 16'h0000;
        end else if (i_inc && !w_sat) begin
            o_bcd <= w_next;
        end
    end

endmodule

// File: rtl/score_tracker.sv
// rtl/score_tracker.sv - kill detection, BCD score/hiscore, level and move_tick pacing
module score_tracker
    import score_tracker_pkg::*;
#(
    parameter int KILLS_PER_LEVEL = 10,
    parameter int BASE_PERIOD     = 50000000,
    parameter int PERIOD_STEP     = 5000000
) (
    input  logic                       clk_game,
    input  logic                       rst_n,
    input  logic                       alive,
    input  logic [MONSTERS*SLOT_W-1:0] state_monsters,
    output logic [15:0]                score_bcd,
    output logic [15:0]                hiscore_bcd,
    output logic [2:0]                 level,
    output logic                       kill_pulse,
    output logic                       move_tick
);

    logic [MONSTERS-1:0] w_valid;
    logic [MONSTERS-1:0] w_kill;
    logic [MONSTERS-1:0] r_v;
    logic                r_alive_d;
    logic [3:0]          r_pending;
    logic [3:0]          r_kills_in_level;
    logic [31:0]         r_tick_cnt;
    logic [3:0]          w_pop;
    logic [5:0]          w_sum;
    logic [3:0]          w_pending_next;
    logic [31:0]         w_period;
    logic                w_start;
    logic                w_over;
    logic                w_credit;
    logic                w_unused_fields;

    assign w_unused_fields = ^state_monsters;
    assign w_start = alive & ~r_alive_d;
    assign w_over  = ~alive & r_alive_d;
    // Credits are only drained while the game is live; leftovers die at the next start
    assign w_credit = (r_pending != 4'd0) & alive & r_alive_d;
    assign w_period = 32'(BASE_PERIOD) - 32'(level) * 32'(PERIOD_STEP);

    always_comb begin
        w_valid = '0;
        w_pop   = '0;
        for (int i = 0; i < MONSTERS; i++) begin
            w_valid[i] = state_monsters[i*SLOT_W + SLOT_VALID];
        end
        w_kill = r_v & ~w_valid & {MONSTERS{alive & r_alive_d}};
        for (int i = 0; i < MONSTERS; i++) begin
            w_pop = w_pop + {3'b000, w_kill[i]};
        end
        w_sum          = {2'b00, r_pending} + {2'b00, w_pop} - {5'b00000, w_credit};
        w_pending_next = (w_sum > 6'd15) ? 4'd15 : w_sum[3:0];
    end

    bcd_counter4 u_score (
        .clk   (clk_game),
        .rst_n (rst_n),
        .i_clr (w_start),
        .i_inc (w_credit),
        .o_bcd (score_bcd)
    );

    always_ff @(posedge clk_game) begin
        if (!rst_n) begin
            r_v              <= '0;
            r_alive_d        <= 1'b0;
            r_pending        <= 4'd0;
            r_kills_in_level <= 4'd0;
            r_tick_cnt       <= 32'd0;
            hiscore_bcd      <= 16'h0000;
            level            <= 3'd0;
            kill_pulse       <= 1'b0;
            move_tick        <= 1'b0;
        end else begin
            r_v        <= w_valid;
            r_alive_d  <= alive;
            kill_pulse <= w_credit;

            if (w_start) begin
                r_pending        <= 4'd0;
                r_kills_in_level <= 4'd0;
                level            <= 3'd0;
            end else begin
                r_pending <= w_pending_next;
                if (w_credit) begin
                    if (r_kills_in_level == 4'(KILLS_PER_LEVEL - 1)) begin
                        r_kills_in_level <= 4'd0;
                        if (level != 3'(MAX_LEVEL)) level <= level + 3'd1;
                    end else begin
                        r_kills_in_level <= r_kills_in_level + 4'd1;
                    end
                end
            end

            // BCD words order the same as their binary values
            if (w_over && (score_bcd > hiscore_bcd)) hiscore_bcd <= score_bcd;

            if (w_start) begin
                r_tick_cnt <= 32'd0;
                move_tick  <= 1'b0;
            end else if (r_tick_cnt >= w_period - 32'd1) begin
                r_tick_cnt <= 32'd0;
                move_tick  <= 1'b1;
            end else begin
                r_tick_cnt <= r_tick_cnt + 32'd1;
                move_tick  <= 1'b0;
            end
        end
    end

endmodule
